// File: rtl/decode_pkg.sv
// Shared decode definitions: opcode/funct encodings, ALU control codes and the
// ID/EX bundle carried from decode to execute.
package decode_pkg;

  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;
  localparam int REG_AW   = $clog2(NUM_REGS);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] FN_ADD   = 6'h20;

  typedef enum logic [3:0] {
    ALU_NOP  = 4'b0000,
    ALU_ADD  = 4'b0001,
    ALU_ADDI = 4'b0010,
    ALU_JUMP = 4'b0011
  } alu_ctrl_e;

  typedef struct packed {
    alu_ctrl_e         alu_ctrl;
    logic [XLEN-1:0]   rs_data;
    logic [XLEN-1:0]   rt_data;
    logic [15:0]       imm;
    logic [XLEN-1:0]   imm_sext;
    logic [REG_AW-1:0] dest;
    logic              reg_write;
    logic [XLEN-1:0]   jtarget;
    logic [XLEN-1:0]   pc;
    logic              illegal;
  } id_ex_t;

endpackage

// File: rtl/regfile.sv
// Architectural register file: two asynchronous read ports, one synchronous
// write port, register 0 hard-wired to zero, async active-low clear.
module regfile
  import decode_pkg::*;
#(
  parameter int W  = XLEN,
  parameter int N  = NUM_REGS,
  parameter int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [W-1:0]  rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [W-1:0]  rdata_b
);

  logic [W-1:0] regs [N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == '0) ? '0 : regs[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 : regs[raddr_b];

endmodule

// File: rtl/decode_stage.sv
// Instruction decode stage: decodes R/I/J instructions, reads the register file
// and holds a one-deep ID/EX bundle. Optional feature macro: WB_BYPASS_EN.
module decode_stage
  import decode_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid,
  output logic        if_ready,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  input  logic        flush,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [3:0]  id_alu_ctrl,
  output logic [31:0] id_rs_data,
  output logic [31:0] id_rt_data,
  output logic [15:0] id_imm,
  output logic [31:0] id_imm_sext,
  output logic [4:0]  id_dest,
  output logic        id_reg_write,
  output logic [31:0] id_jtarget,
  output logic [31:0] id_pc,
  output logic        id_illegal
);

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] rs_file, rt_file, rs_val, rt_val;
  logic        accept;
  logic        id_valid_q;
  id_ex_t      dec, id_q;

  assign op    = if_instr[31:26];
  assign rs    = if_instr[25:21];
  assign rt    = if_instr[20:16];
  assign rd    = if_instr[15:11];
  assign funct = if_instr[5:0];

  regfile u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (wb_en),
    .waddr   (wb_addr),
    .wdata   (wb_data),
    .raddr_a (rs),
    .rdata_a (rs_file),
    .raddr_b (rt),
    .rdata_b (rt_file)
  );

`ifdef WB_BYPASS_EN
  assign rs_val = (wb_en && (wb_addr != 5'd0) && (wb_addr == rs)) ? wb_data : rs_file;
  assign rt_val = (wb_en && (wb_addr != 5'd0) && (wb_addr == rt)) ? wb_data : rt_file;
`else
  assign rs_val = rs_file;
  assign rt_val = rt_file;
`endif

  // Valid/ready: a beat moves when valid & ready on the same edge. Upstream may
  // load whenever the bundle is empty or leaving; flush opens the input but
  // drops whatever is offered in that cycle.
  assign if_ready = flush | ~id_valid_q | id_ready;
  assign accept   = if_valid & if_ready & ~flush;

  always_comb begin
    dec           = '0;
    dec.rs_data   = rs_val;
    dec.rt_data   = rt_val;
    dec.imm       = if_instr[15:0];
    dec.imm_sext  = {{16{if_instr[15]}}, if_instr[15:0]};
    dec.jtarget   = {if_pc[31:28], if_instr[25:0], 2'b00};
    dec.pc        = if_pc;
    dec.alu_ctrl  = ALU_NOP;
    dec.illegal   = 1'b1;
    if (op == OP_RTYPE && funct == FN_ADD) begin
      dec.alu_ctrl  = ALU_ADD;
      dec.dest      = rd;
      dec.reg_write = 1'b1;
      dec.illegal   = 1'b0;
    end else if (op == OP_ADDI) begin
      dec.alu_ctrl  = ALU_ADDI;
      dec.dest      = rt;
      dec.reg_write = 1'b1;
      dec.illegal   = 1'b0;
    end else if (op == OP_J) begin
      dec.alu_ctrl  = ALU_JUMP;
      dec.dest      = 5'd31;
      dec.reg_write = 1'b1;
      dec.illegal   = 1'b0;
    end
  end

  // Register data is captured at accept so a stalled bundle never re-reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid_q <= 1'b0;
      id_q       <= '0;
      id_q.pc    <= RESET_PC;
    end else if (flush) begin
      id_valid_q <= 1'b0;
    end else if (accept) begin
      id_valid_q <= 1'b1;
      id_q       <= dec;
    end else if (id_ready) begin
      id_valid_q <= 1'b0;
    end
  end

  assign id_valid     = id_valid_q;
  assign id_alu_ctrl  = id_q.alu_ctrl;
  assign id_rs_data   = id_q.rs_data;
  assign id_rt_data   = id_q.rt_data;
  assign id_imm       = id_q.imm;
  assign id_imm_sext  = id_q.imm_sext;
  assign id_dest      = id_q.dest;
  assign id_reg_write = id_q.reg_write;
  assign id_jtarget   = id_q.jtarget;
  assign id_pc        = id_q.pc;
  assign id_illegal   = id_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed cases followed by random
// traffic against a behavioural model of the decode rules and register file.
module tb_decode_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid, if_ready, flush, wb_en, id_ready;
  logic [31:0] if_instr, if_pc, wb_data;
  logic [4:0]  wb_addr;
  logic        id_valid, id_reg_write, id_illegal;
  logic [3:0]  id_alu_ctrl;
  logic [31:0] id_rs_data, id_rt_data, id_imm_sext, id_jtarget, id_pc;
  logic [15:0] id_imm;
  logic [4:0]  id_dest;

  decode_stage #(.RESET_PC(RESET_PC)) dut (
    .clk (clk), .rst_n (rst_n),
    .if_valid (if_valid), .if_ready (if_ready), .if_instr (if_instr), .if_pc (if_pc),
    .flush (flush), .wb_en (wb_en), .wb_addr (wb_addr), .wb_data (wb_data),
    .id_valid (id_valid), .id_ready (id_ready), .id_alu_ctrl (id_alu_ctrl),
    .id_rs_data (id_rs_data), .id_rt_data (id_rt_data), .id_imm (id_imm),
    .id_imm_sext (id_imm_sext), .id_dest (id_dest), .id_reg_write (id_reg_write),
    .id_jtarget (id_jtarget), .id_pc (id_pc), .id_illegal (id_illegal)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  alu;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [15:0] imm;
    logic [31:0] imm_sext;
    logic [4:0]  dest;
    logic        reg_write;
    logic [31:0] jtarget;
    logic [31:0] pc;
    logic        illegal;
  } exp_t;
  localparam int W = $bits(exp_t);

  logic [W-1:0] exp_q[$];
  logic [31:0]  ref_regs [32];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] read_reg(input int idx);
    if (idx == 0) return 32'd0;
`ifdef WB_BYPASS_EN
    if (wb_en && int'(wb_addr) == idx) return wb_data;
`endif
    return ref_regs[idx];
  endfunction

  function automatic exp_t model(input logic [31:0] instr, input logic [31:0] pc);
    exp_t e;
    int unsigned op, funct, rs, rt, rd, imm;
    op    = instr >> 26;
    funct = instr % 64;
    rs    = (instr >> 21) % 32;
    rt    = (instr >> 16) % 32;
    rd    = (instr >> 11) % 32;
    imm   = instr % 65536;
    e = '0;
    e.rs_data  = read_reg(rs);
    e.rt_data  = read_reg(rt);
    e.imm      = 16'(imm);
    e.imm_sext = (imm >= 32768) ? imm + 32'hFFFF_0000 : imm;
    e.jtarget  = (pc & 32'hF000_0000) | ((instr % (1 << 26)) * 4);
    e.pc       = pc;
    if (op == 0 && funct == 32)  begin e.alu = 4'd1; e.dest = 5'(rd); e.reg_write = 1'b1; end
    else if (op == 8)            begin e.alu = 4'd2; e.dest = 5'(rt); e.reg_write = 1'b1; end
    else if (op == 2)            begin e.alu = 4'd3; e.dest = 5'd31;  e.reg_write = 1'b1; end
    else                         begin e.alu = 4'd0; e.illegal = 1'b1; end
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    int kind;
    logic [31:0] r;
    int unsigned op;
    kind = $urandom_range(0, 4);
    r = $urandom;
    op = $urandom_range(9, 63);
    case (kind)
      0: return (r & 32'h03FF_F800) | 32'h20;
      1: return (r & 32'h03FF_FFFF) | 32'h2000_0000;
      2: return (r & 32'h03FF_FFFF) | 32'h0800_0000;
      3: return (r & 32'h03FF_FFFF) | (op << 26);
      default: return (r & 32'h03FF_FFC0) | $urandom_range(0, 31);
    endcase
  endfunction

  // driver tasks
  task automatic drive(input logic iv, input logic [31:0] instr, input logic [31:0] pc,
                       input logic fl, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic rdy);
    if_valid = iv; if_instr = instr; if_pc = pc; flush = fl;
    wb_en = we; wb_addr = wa; wb_data = wd; id_ready = rdy;
  endtask

  task automatic check_outputs();
    exp_t e;
    check("id_valid", id_valid, (exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      e = exp_t'(exp_q[0]);
      check("alu_ctrl", id_alu_ctrl, e.alu);
      check("rs_data", id_rs_data, e.rs_data);
      check("rt_data", id_rt_data, e.rt_data);
      check("imm", id_imm, e.imm);
      check("imm_sext", id_imm_sext, e.imm_sext);
      if (!e.illegal) check("dest", id_dest, e.dest);
      check("reg_write", id_reg_write, e.reg_write);
      check("jtarget", id_jtarget, e.jtarget);
      check("pc", id_pc, e.pc);
      check("illegal", id_illegal, e.illegal);
    end
  endtask

  // One clock: check if_ready on the settled inputs, advance the model, check outputs.
  task automatic step();
    logic exp_if_ready, acc;
    exp_t e;
    #1;
    exp_if_ready = flush || (exp_q.size() == 0) || id_ready;
    check("if_ready", if_ready, exp_if_ready);
    acc = if_valid && exp_if_ready && !flush;
    e = model(if_instr, if_pc);
    @(posedge clk);
    if (flush) exp_q.delete();
    else begin
      if (exp_q.size() != 0 && id_ready) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(W'(e));
    end
    if (wb_en && wb_addr != 5'd0) ref_regs[wb_addr] = wb_data;
    #1 check_outputs();
  endtask

  task automatic rand_cycle();
    drive(($urandom_range(0, 9) < 7), rand_instr(), $urandom & 32'hFFFF_FFFC,
          ($urandom_range(0, 15) == 0), $urandom_range(0, 1), 5'($urandom_range(0, 31)),
          $urandom, ($urandom_range(0, 9) < 7));
    step();
  endtask

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    check("rst_valid", id_valid, 0);
    check("rst_alu", id_alu_ctrl, 0);
    check("rst_pc", id_pc, RESET_PC);
    check("rst_rs", id_rs_data, 0);
    check("rst_jtarget", id_jtarget, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    drive(0, 0, 0, 0, 1, 5'd1, 32'd5, 1); step();
    drive(0, 0, 0, 0, 1, 5'd2, 32'd7, 1); step();

    drive(1, 32'h0022_1820, 32'h100, 0, 0, 0, 0, 1); step();
    check("add_alu", id_alu_ctrl, 4'b0001);
    check("add_rs", id_rs_data, 5);
    check("add_rt", id_rt_data, 7);
    check("add_dest", id_dest, 3);

    drive(1, 32'h2022_FFFE, 32'h104, 0, 0, 0, 0, 1); step();
    check("addi_alu", id_alu_ctrl, 4'b0010);
    check("addi_sext", id_imm_sext, 32'hFFFF_FFFE);
    check("addi_dest", id_dest, 2);

    drive(1, 32'h0800_0004, 32'h4000_0010, 0, 0, 0, 0, 1); step();
    check("j_alu", id_alu_ctrl, 4'b0011);
    check("j_target", id_jtarget, 32'h4000_0010);
    check("j_dest", id_dest, 31);

    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h0022_1820, 32'h200, 0, 0, 0, 0, 0); step();
      check("stall_if_ready", if_ready, 0);
      check("stall_alu", id_alu_ctrl, 4'b0011);
      check("stall_pc", id_pc, 32'h4000_0010);
    end

    drive(1, 32'h0022_1820, 32'h204, 1, 1, 5'd4, 32'd9, 0); step();
    check("flush_valid", id_valid, 0);

    drive(1, 32'h0022_1820, 32'h300, 0, 1, 5'd1, 32'h55, 1); step();
`ifdef WB_BYPASS_EN
    check("bypass_rs", id_rs_data, 32'h55);
`else
    check("bypass_rs", id_rs_data, 32'd5);
`endif

    drive(1, 32'h0080_2820, 32'h304, 0, 1, 5'd0, 32'hDEAD, 1); step();
    check("flush_wb_r4", id_rs_data, 32'd9);
    check("r0_zero", id_rt_data, 32'd0);

    repeat (400) rand_cycle();

    drive(1, rand_instr(), 32'h500, 0, 0, 0, 0, 0); step();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("mid_rst_valid", id_valid, 0);
    check("mid_rst_alu", id_alu_ctrl, 0);
    check("mid_rst_pc", id_pc, RESET_PC);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step();

    repeat (150) rand_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
